pattern_scan_ctrl: RTL and testbench

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

---
 rtl/pattern_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Serial 4-bit pattern scanner with IDLE/SCAN/DONE control, optional overlap,
// and a saturating match counter with an optional auto-stop limit.
module pattern_scan_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             start,
  input  logic             abort,
  input  logic             x_valid,
  input  logic             x,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PAT_W = 4;
  localparam int unsigned WIN_W = PAT_W - 1;
  localparam int unsigned FIL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [PAT_W-1:0]   r_pat;
  logic               r_ovl;
  logic [CNT_W-1:0]   r_lim;
  logic [WIN_W-1:0]   r_w;
  logic [FIL_W-1:0]   r_f;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;

  logic               w_acc;
  logic               w_z;
  logic [CNT_W:0]     w_cnt_inc;
  logic               w_hit_lim;

  // A bit is consumed only while scanning and not being aborted.
  assign w_acc     = (r_state == SCAN) && x_valid && !abort;
  assign w_z       = w_acc && (r_f == FIL_W'(3)) && ({r_w, x} == r_pat);
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);
  assign w_hit_lim = (r_lim != '0) && (w_cnt_inc == {1'b0, r_lim});

  assign z         = w_z;
  assign match_cnt = r_cnt;
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_ovl   <= 1'b0;
      r_lim   <= '0;
      r_w     <= '0;
      r_f     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Config write wins over a simultaneous start.
          if (cfg_we) begin
            r_pat <= cfg_pattern;
            r_ovl <= cfg_overlap;
            r_lim <= cfg_limit;
          end else if (start) begin
            r_state <= SCAN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_w     <= '0;
            r_f     <= '0;
          end
        end
        SCAN: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (x_valid) begin
            r_w <= {r_w[WIN_W-2:0], x};
            if (w_z && !r_ovl) begin
              r_f <= '0;
            end else if (r_f != FIL_W'(3)) begin
              r_f <= r_f + FIL_W'(1);
            end
            if (w_z) begin
              if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= w_cnt_inc[CNT_W-1:0];
              end
              if (w_hit_lim) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl; expected z values flow through a
// scoreboard queue, counters and status are checked against fixed values.
module tb_pattern_scan_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [3:0]       cfg_pattern;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_limit;
  logic             start;
  logic             abort;
  logic             x_valid;
  logic             x;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;

  int   n_checks;
  int   n_errors;
  logic q_z[$];

  pattern_scan_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .cfg_limit   (cfg_limit),
    .start       (start),
    .abort       (abort),
    .x_valid     (x_valid),
    .x           (x),
    .z           (z),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge; z is sampled 1 time unit later.
  task automatic bit_step(input string tag, input logic v, input logic b,
                          input logic ab, input logic ez);
    logic e;
    x_valid = v;
    x       = b;
    abort   = ab;
    q_z.push_back(ez);
    #1;
    if (q_z.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = q_z.pop_front();
      check(tag, 32'(z), 32'(e));
    end
    @(negedge clk);
    x_valid = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic configure(input logic [3:0] p, input logic o, input logic [CNT_W-1:0] l);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_overlap = o;
    cfg_limit   = l;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic go(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_cnt0"}, 32'(match_cnt), 32'd0);
  endtask

  task automatic stop(input string tag, input logic [CNT_W-1:0] ecnt);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_cnt"}, 32'(match_cnt), 32'(ecnt));
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    cfg_we      = 1'b0;
    cfg_pattern = 4'b0000;
    cfg_overlap = 1'b0;
    cfg_limit   = '0;
    start       = 1'b0;
    abort       = 1'b0;
    x_valid     = 1'b0;
    x           = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    check("rst_z", 32'(z), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Non-overlapping 1010; cfg_we together with start must not start a scan.
    cfg_we = 1'b1; start = 1'b1;
    cfg_pattern = 4'b1010; cfg_overlap = 1'b0; cfg_limit = '0;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    check("cfg_start_idle", 32'(busy), 32'd0);
    go("t1");
    bit_step("t1_b1", 1, 1, 0, 0);
    bit_step("t1_b2", 1, 0, 0, 0);
    bit_step("t1_b3", 1, 1, 0, 0);
    bit_step("t1_b4", 1, 0, 0, 1);
    bit_step("t1_b5", 1, 1, 0, 0);
    bit_step("t1_b6", 1, 0, 0, 0);
    check("t1_cnt", 32'(match_cnt), 32'd1);
    stop("t1_end", 8'd1);

    // Overlapping 1010.
    configure(4'b1010, 1'b1, 8'd0);
    go("t2");
    bit_step("t2_b1", 1, 1, 0, 0);
    bit_step("t2_b2", 1, 0, 0, 0);
    bit_step("t2_b3", 1, 1, 0, 0);
    bit_step("t2_b4", 1, 0, 0, 1);
    bit_step("t2_b5", 1, 1, 0, 0);
    bit_step("t2_b6", 1, 0, 0, 1);
    stop("t2_end", 8'd2);

    // Limit of 3 on all-ones: auto-stop into DONE for one cycle.
    configure(4'b1111, 1'b1, 8'd3);
    go("t3");
    bit_step("t3_b1", 1, 1, 0, 0);
    bit_step("t3_b2", 1, 1, 0, 0);
    bit_step("t3_b3", 1, 1, 0, 0);
    bit_step("t3_b4", 1, 1, 0, 1);
    bit_step("t3_b5", 1, 1, 0, 1);
    check("t3_busy_mid", 32'(busy), 32'd1);
    bit_step("t3_b6", 1, 1, 0, 1);
    check("t3_done", 32'(done), 32'd1);
    check("t3_busy_done", 32'(busy), 32'd0);
    check("t3_cnt", 32'(match_cnt), 32'd3);
    bit_step("t3_x7", 1, 1, 1, 0);
    check("t3_done_1cyc", 32'(done), 32'd0);
    check("t3_busy_idle", 32'(busy), 32'd0);
    bit_step("t3_x8", 1, 1, 0, 0);
    check("t3_cnt_hold", 32'(match_cnt), 32'd3);

    // Idle x_valid gaps must not disturb the window.
    configure(4'b1010, 1'b0, 8'd0);
    go("t4");
    bit_step("t4_b1", 1, 1, 0, 0);
    bit_step("t4_g1", 0, 1, 0, 0);
    bit_step("t4_g2", 0, 1, 0, 0);
    bit_step("t4_b2", 1, 0, 0, 0);
    bit_step("t4_g3", 0, 0, 0, 0);
    bit_step("t4_g4", 0, 0, 0, 0);
    bit_step("t4_b3", 1, 1, 0, 0);
    bit_step("t4_g5", 0, 0, 0, 0);
    bit_step("t4_g6", 0, 0, 0, 0);
    bit_step("t4_b4", 1, 0, 0, 1);
    check("t4_cnt", 32'(match_cnt), 32'd1);
    stop("t4_end", 8'd1);

    // Abort on the matching bit; cfg_we during SCAN is ignored.
    go("t5");
    bit_step("t5_b1", 1, 1, 0, 0);
    bit_step("t5_b2", 1, 0, 0, 0);
    cfg_we = 1'b1; cfg_pattern = 4'b1111; cfg_overlap = 1'b1; cfg_limit = 8'd1;
    bit_step("t5_b3", 1, 1, 0, 0);
    cfg_we = 1'b0;
    bit_step("t5_b4ab", 1, 0, 1, 0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_cnt", 32'(match_cnt), 32'd0);
    @(negedge clk);
    check("t5_done2", 32'(done), 32'd0);
    go("t5r");
    bit_step("t5r_b1", 1, 1, 0, 0);
    bit_step("t5r_b2", 1, 0, 0, 0);
    bit_step("t5r_b3", 1, 1, 0, 0);
    bit_step("t5r_b4", 1, 0, 0, 1);
    check("t5r_busy", 32'(busy), 32'd1);
    stop("t5r_end", 8'd1);

    // Reset mid-scan after two matches.
    configure(4'b1111, 1'b1, 8'd0);
    go("t6");
    bit_step("t6_b1", 1, 1, 0, 0);
    bit_step("t6_b2", 1, 1, 0, 0);
    bit_step("t6_b3", 1, 1, 0, 0);
    bit_step("t6_b4", 1, 1, 0, 1);
    bit_step("t6_b5", 1, 1, 0, 1);
    check("t6_cnt2", 32'(match_cnt), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_cnt_rst", 32'(match_cnt), 32'd0);
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_done_rst", 32'(done), 32'd0);
    bit_step("t6_n1", 1, 0, 0, 0);
    bit_step("t6_n2", 1, 0, 0, 0);
    bit_step("t6_n3", 1, 0, 0, 0);
    bit_step("t6_n4", 1, 0, 0, 0);
    go("t6s");
    bit_step("t6s_b1", 1, 0, 0, 0);
    bit_step("t6s_b2", 1, 0, 0, 0);
    bit_step("t6s_b3", 1, 0, 0, 0);
    bit_step("t6s_b4", 1, 0, 0, 1);
    stop("t6s_end", 8'd1);

    check("sb_empty", 32'(q_z.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
